alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 8-bit ALU.
- Accepts operand pairs plus an opcode over a valid/ready handshake.
- Computes through a 2-stage pipeline and returns the result with status flags (zero, negative, carry, overflow, error).
- Honours downstream back-pressure without losing or reordering operations.
- Sits between the operand-loading front end and the result display/consumer.

Parameters:
- NB_DATA, 8, operand and result width in bits (must be >= 2).
- NB_OPCODE, 6, opcode width in bits (opcode encodings fixed, zero-extended if wider).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode beat present.
- in_ready  output  1  block can accept the beat this cycle.
- dato_a  input  NB_DATA  operand A.
- dato_b  input  NB_DATA  operand B (shift amount for SRA/SRL).
- opcode  input  NB_OPCODE  operation select.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  NB_DATA  result.
- flag_zero  output  1  out == 0.
- flag_neg  output  1  out[NB_DATA-1].
- flag_carry  output  1  ADD carry-out / SUB borrow; 0 otherwise.
- flag_ovf  output  1  signed overflow for ADD/SUB; 0 otherwise.
- flag_err  output  1  opcode not in the supported set.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, port rst_n.
- Reset (async assert, sync-safe deassert assumed external):
  - s1_valid = s2_valid = 0; out_valid = 0.
  - out and all flags = 0.
  - in_ready = 1 once rst_n is high.
- Stage 1 (S1): registers dato_a, dato_b and opcode on the handshake (in_valid && in_ready).
- Stage 2 (S2): registers the combinational result and flags computed from S1. S2 drives out, flags and out_valid directly from registers.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no combinational path from in_valid).
- Latency: result appears 2 cycles after acceptance; throughput 1 op/cycle with out_ready held high.
- Holding: while out_valid && !out_ready, out and flags stay stable; S1 holds if full; no beat is dropped or duplicated.
- Simultaneous accept and drain in the same cycle is legal; occupancy stays constant.
- Operations (arithmetic modulo 2^NB_DATA):
  - ADD 100000: a+b; carry = bit NB_DATA of the (NB_DATA+1)-bit sum; ovf = sign(a)==sign(b) && sign(out)!=sign(a).
  - SUB 100010: a-b; carry = borrow (a < b unsigned); ovf = sign(a)!=sign(b) && sign(out)!=sign(a).
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise.
  - SRL 000010: a >> b logical. Shift by the full unsigned b; b >= NB_DATA gives 0.
  - SRA 000011: a >>> b arithmetic; b >= NB_DATA gives all bits = a[NB_DATA-1].
  - Any other opcode: out = 0, flag_err = 1, flag_zero = 1, other flags 0.
- Flags zero/neg are computed from the final out for every opcode.
- Reset mid-operation: in-flight beats are discarded; out_valid drops immediately on rst_n low.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams ADD, SUB, AND, OR, XOR, NOR, SRL, SRA;
  - the flag bit order, packed as {err, ovf, carry, neg, zero}.
- One sub-module, alu_exec: purely combinational, parametrised by NB_DATA and NB_OPCODE. Maps (a, b, opcode) to (result, flags).
- alu_pipe contains only the handshake, the S1/S2 registers and the valid logic.

Test Plan:
- ADD 0x7F+0x01, out_ready=1 -> out 0x80, neg=1, ovf=1, carry=0, zero=0; out_valid exactly 2 cycles after acceptance.
- SUB 0x00-0x01 -> out 0xFF, carry=1, neg=1, ovf=0. SUB 0x80-0x01 -> 0x7F, ovf=1.
- Shifts on a=0x80:
  - SRA by 3 -> 0xF0; SRL by 3 -> 0x10.
  - SRL by 9 -> 0x00, zero=1; SRA by 9 -> 0xFF.
- Illegal opcode 6'b111111 with a=0x55, b=0xAA -> out 0x00, err=1, zero=1, carry=ovf=neg=0.
- Back-pressure:
  - Offer 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=0.
  - Expect in_ready to drop after 2 accepts and out to hold 0x02.
  - Release out_ready; expect 0x02, 0x04, 0x06, 0x08 in order, each exactly once.
- Reset mid-stream: assert rst_n=0 with S1 and S2 full -> out_valid=0 and out=0 without waiting for a clock edge. After release, in_ready=1 and no stale result emerges.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and flag layout shared by the ALU pipeline.
package alu_pkg;

    localparam int NB_OPCODE_BASE = 6;

    localparam logic [NB_OPCODE_BASE-1:0] ADD = 6'b100000;
    localparam logic [NB_OPCODE_BASE-1:0] SUB = 6'b100010;
    localparam logic [NB_OPCODE_BASE-1:0] AND = 6'b100100;
    localparam logic [NB_OPCODE_BASE-1:0] OR  = 6'b100101;
    localparam logic [NB_OPCODE_BASE-1:0] XOR = 6'b100110;
    localparam logic [NB_OPCODE_BASE-1:0] NOR = 6'b100111;
    localparam logic [NB_OPCODE_BASE-1:0] SRL = 6'b000010;
    localparam logic [NB_OPCODE_BASE-1:0] SRA = 6'b000011;

    localparam int NB_FLAGS = 5;

    // Packed so that zero lands in bit 0 and err in bit 4.
    typedef struct packed {
        logic err;
        logic ovf;
        logic carry;
        logic neg;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - combinational ALU core mapping (a, b, opcode) to result and flags.
module alu_exec
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic [NB_DATA-1:0]   a_i,
    input  logic [NB_DATA-1:0]   b_i,
    input  logic [NB_OPCODE-1:0] opcode_i,
    output logic [NB_DATA-1:0]   result_o,
    output alu_flags_t           flags_o
);

    localparam int MSB = NB_DATA - 1;

    // Base encodings are zero-extended to the configured opcode width.
    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(ADD);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(SUB);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(AND);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(OR);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(XOR);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(NOR);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(SRL);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(SRA);

    logic [NB_DATA:0] sum;
    logic [NB_DATA:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        case (opcode_i)
            OP_ADD: begin
                result_o      = sum[MSB:0];
                flags_o.carry = sum[NB_DATA];
                flags_o.ovf   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                result_o      = diff[MSB:0];
                flags_o.carry = diff[NB_DATA];
                flags_o.ovf   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_SRL:  result_o = a_i >> b_i;
            OP_SRA:  result_o = NB_DATA'($signed(a_i) >>> b_i);
            default: flags_o.err = 1'b1;
        endcase
        flags_o.zero = (result_o == '0);
        flags_o.neg  = result_o[MSB];
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline wrapped around alu_exec.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NB_DATA-1:0]   dato_a,
    input  logic [NB_DATA-1:0]   dato_b,
    input  logic [NB_OPCODE-1:0] opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NB_DATA-1:0]   out,
    output logic                 flag_zero,
    output logic                 flag_neg,
    output logic                 flag_carry,
    output logic                 flag_ovf,
    output logic                 flag_err
);

    logic                 s1_valid_q, s1_valid_d;
    logic [NB_DATA-1:0]   s1_a_q, s1_a_d;
    logic [NB_DATA-1:0]   s1_b_q, s1_b_d;
    logic [NB_OPCODE-1:0] s1_op_q, s1_op_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [NB_DATA-1:0]   s2_out_q, s2_out_d;
    alu_flags_t           s2_flags_q, s2_flags_d;

    logic                 s1_adv, s2_adv;
    logic [NB_DATA-1:0]   exec_result;
    alu_flags_t           exec_flags;

    alu_exec #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE)
    ) u_exec (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .opcode_i (s1_op_q),
        .result_o (exec_result),
        .flags_o  (exec_flags)
    );

    // A stage may advance when it is empty or its successor is advancing.
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;

        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv && in_valid) begin
            s1_a_d  = dato_a;
            s1_b_d  = dato_b;
            s1_op_d = opcode;
        end

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_out_d   = s2_out_q;
        s2_flags_d = s2_flags_q;
        if (s2_adv && s1_valid_q) begin
            s2_out_d   = exec_result;
            s2_flags_d = exec_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_out_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_out_q   <= s2_out_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out        = s2_out_q;
    assign flag_zero  = s2_flags_q.zero;
    assign flag_neg   = s2_flags_q.neg;
    assign flag_carry = s2_flags_q.carry;
    assign flag_ovf   = s2_flags_q.ovf;
    assign flag_err   = s2_flags_q.err;

endmodule
